pipeline_perf_monitor: RTL and testbench
========================================

// Module: pipeline_perf_monitor
// PURPOSE
//   Cycle-accurate event counter that sits beside the 5-stage CPU, downstream of its
//   hazard-detection and MEM/WB logic, and consumes their status signals.
//   Counts run cycles, stalls, flushes and retired instructions between start and halt.
//   Exposes the counts through a registered read port, so benches and the debug
//   printer stop probing hierarchical CPU nets.
// PARAMETERS
//   CNT_W        32   width of every counter and of rd_data_o
//   CYCLE_LIMIT  30   run cycles before automatic DONE; 0 = no limit (halt_i only)
// PORTS
//   clk_i           in   1      clock; all state changes on posedge
//   rst_i           in   1      reset, synchronous, active-high
//   start_i         in   1      CPU start; arms the monitor
//   stall_i         in   1      hazard unit stall request
//   branch_i        in   1      control-unit Branch; masks stall counting
//   flush_i         in   1      hazard unit flush request
//   retire_i        in   1      MEM/WB RegWrite or store, i.e. instruction retired
//   halt_i          in   1      end-of-program indication
//   rd_req_i        in   1      counter read request
//   rd_sel_i        in   2      0=cycle 1=stall 2=flush 3=retire
//   rd_valid_o      out  1      read data valid, one-cycle pulse per request
//   rd_data_o       out  CNT_W  selected counter value
//   running_o       out  1      state == RUN
//   done_o          out  1      state == DONE
// BEHAVIOUR
//   - Reset (rst_i=1 at an edge):
//     - state IDLE; all four counters 0.
//     - rd_valid_o=0, rd_data_o=0, running_o=0, done_o=0.
//     - Reset overrides every other input, including mid-run and with a read pending.
//   - FSM: IDLE -> RUN -> DONE; DONE is left only by reset.
//   - IDLE:
//     - Counters hold.
//     - start_i=1 at an edge moves to RUN. That edge counts nothing.
//   - RUN: at every edge, before any transition:
//     - cycle_cnt += 1.
//     - stall_cnt += 1 iff stall_i & ~branch_i.
//     - flush_cnt += 1 iff flush_i.
//     - retire_cnt += 1 iff retire_i.
//     - Events are independent; any combination in one cycle is counted in full.
//     - start_i is sticky: deasserting it in RUN has no effect.
//   - RUN -> DONE at the edge where halt_i=1, or where (CYCLE_LIMIT!=0 and cycle_cnt+1 == CYCLE_LIMIT).
//     - Events sampled at that edge are still counted, so the final cycle_cnt equals CYCLE_LIMIT.
//   - DONE: counters frozen; start_i, halt_i and event inputs are ignored.
//   - Saturation: each counter stops at 2^CNT_W-1 and never wraps. The other counters continue.
//   - Read port:
//     - rd_req_i=1 at edge N gives rd_valid_o=1 after edge N.
//     - rd_data_o = the selected counter value held before edge N's update (pre-increment snapshot).
//     - Latency is 1 cycle. A request every cycle gives valid data every cycle. Reads are legal in any state.
//     - With no request, rd_valid_o=0 and rd_data_o holds its last value.
//   - running_o and done_o are decoded from the state register. They are never both 1.
// TESTING
//   T1 reset, start_i=0 for 5 cycles, read sel0 -> rd_valid_o=1, rd_data_o=0, running_o=0.
//   T2 start; 10 RUN cycles stall_i=1, branch_i toggling 0/1 -> stall=5, cycle=10, flush=0.
//   T3 stall_i=flush_i=retire_i=1, branch_i=0 for 3 RUN cycles -> stall=flush=retire=3.
//   T4 CYCLE_LIMIT=30 free run -> done_o rises after 30th RUN edge, cycle=30; later events leave counts unchanged.
//   T5 CNT_W=4, CYCLE_LIMIT=0, retire_i=1 for 20 cycles -> retire=15, cycle=15 (both saturated).
//   T6 rst_i=1 mid-RUN with rd_req_i=1 same edge -> next cycle rd_valid_o=0, all counts 0, IDLE.

Source files
------------

// File: rtl/pipeline_perf_monitor.sv
// rtl/pipeline_perf_monitor.sv - run/stall/flush/retire event counters with a registered read port
`timescale 1ns/1ps

module pipeline_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic             halt_i,
    input  logic             rd_req_i,
    input  logic [1:0]       rd_sel_i,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             running_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   LIMIT_ONE = 1;
    localparam logic [CNT_W:0]   LIMIT_V   = (CNT_W+1)'(CYCLE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             limit_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end
        return v;
    endfunction

    // Compared one bit wider so a limit equal to 2^CNT_W still compares cleanly.
    assign limit_hit = (CYCLE_LIMIT != 0) && (({1'b0, cycle_q} + LIMIT_ONE) == LIMIT_V);

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        retire_d = retire_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_d  = sat_inc(cycle_q, 1'b1);
                stall_d  = sat_inc(stall_q, stall_i & ~branch_i);
                flush_d  = sat_inc(flush_q, flush_i);
                retire_d = sat_inc(retire_q, retire_i);
                if (halt_i || limit_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reads return the value held before this edge's count update.
    always_comb begin
        rd_valid_d = rd_req_i;
        rd_data_d  = rd_data_q;
        if (rd_req_i) begin
            case (rd_sel_i)
                2'd0:    rd_data_d = cycle_q;
                2'd1:    rd_data_d = stall_q;
                2'd2:    rd_data_d = flush_q;
                default: rd_data_d = retire_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cycle_q    <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            retire_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            retire_q   <= retire_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign running_o  = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb/tb_pipeline_perf_monitor.sv - scoreboard bench for pipeline_perf_monitor (default and 4-bit saturating instances)
`timescale 1ns/1ps

module tb_pipeline_perf_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stall = 1'b0, branch = 1'b0, flush = 1'b0;
    logic        retire = 1'b0, halt = 1'b0;
    logic        rd_req_a = 1'b0, rd_req_b = 1'b0;
    logic [1:0]  rd_sel = 2'd0;
    logic        rd_valid_a, running_a, done_a;
    logic [31:0] rd_data_a;
    logic        rd_valid_b, running_b, done_b;
    logic [3:0]  rd_data_b;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    always #5 clk = ~clk;

    pipeline_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .flush_i(flush), .retire_i(retire), .halt_i(halt), .rd_req_i(rd_req_a),
        .rd_sel_i(rd_sel), .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a),
        .running_o(running_a), .done_o(done_a)
    );

    pipeline_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .flush_i(flush), .retire_i(retire), .halt_i(halt), .rd_req_i(rd_req_b),
        .rd_sel_i(rd_sel), .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b),
        .running_o(running_b), .done_o(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input bit use_b, input logic [1:0] sel, input logic [31:0] e);
        rd_sel = sel;
        if (use_b) begin
            rd_req_b = 1'b1;
            exp_b.push_back(e);
        end else begin
            rd_req_a = 1'b1;
            exp_a.push_back(e);
        end
        tick();
        rd_req_a = 1'b0;
        rd_req_b = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_valid_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_a_unexpected: got valid data %0d expected no valid", rd_data_a);
            end else begin
                chk("rd_a_data", rd_data_a, exp_a.pop_front());
            end
        end
        if (rd_valid_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_b_unexpected: got valid data %0d expected no valid", rd_data_b);
            end else begin
                chk("rd_b_data", 32'(rd_data_b), exp_b.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // T1: reset state and idle hold
        tick();
        tick();
        chk("rst_rd_valid", 32'(rd_valid_a), 0);
        chk("rst_rd_data", rd_data_a, 0);
        chk("rst_running", 32'(running_a), 0);
        chk("rst_done", 32'(done_a), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_running", 32'(running_a), 0);
        rd(0, 2'd0, 0);
        chk("idle_after_read_running", 32'(running_a), 0);

        // T2: start, stall with branch masking on alternate cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_running", 32'(running_a), 1);
        for (int i = 0; i < 10; i++) begin
            stall  = 1'b1;
            branch = (i % 2) == 1;
            tick();
        end
        stall  = 1'b0;
        branch = 1'b0;
        rd(0, 2'd0, 10);
        rd(0, 2'd1, 5);
        rd(0, 2'd2, 0);

        // T3: all events together for three cycles
        stall  = 1'b1;
        flush  = 1'b1;
        retire = 1'b1;
        repeat (3) tick();
        stall  = 1'b0;
        flush  = 1'b0;
        retire = 1'b0;
        rd(0, 2'd1, 8);
        rd(0, 2'd2, 3);
        rd(0, 2'd3, 3);
        rd(0, 2'd0, 19);

        // T4: free run into the cycle limit, then frozen
        n = 0;
        while (!done_a && n < 50) begin
            tick();
            n++;
        end
        chk("limit_edges_to_done", 32'(n), 10);
        chk("limit_running", 32'(running_a), 0);
        stall  = 1'b1;
        flush  = 1'b1;
        retire = 1'b1;
        halt   = 1'b1;
        start  = 1'b1;
        repeat (5) tick();
        stall  = 1'b0;
        flush  = 1'b0;
        retire = 1'b0;
        halt   = 1'b0;
        start  = 1'b0;
        rd(0, 2'd0, 30);
        rd(0, 2'd1, 8);
        rd(0, 2'd2, 3);
        rd(0, 2'd3, 3);
        chk("done_held", 32'(done_a), 1);

        // T6: reset mid-run with a read on the same edge
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        retire = 1'b1;
        repeat (4) tick();
        retire   = 1'b0;
        rst      = 1'b1;
        rd_req_a = 1'b1;
        rd_sel   = 2'd3;
        tick();
        rst      = 1'b0;
        rd_req_a = 1'b0;
        chk("midrst_rd_valid", 32'(rd_valid_a), 0);
        chk("midrst_rd_data", rd_data_a, 0);
        chk("midrst_running", 32'(running_a), 0);
        chk("midrst_done", 32'(done_a), 0);
        rd(0, 2'd0, 0);
        rd(0, 2'd3, 0);

        // halt_i ends the run and its edge is still counted
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_done", 32'(done_a), 1);
        rd(0, 2'd0, 4);

        // T5: 4-bit counters saturate without a cycle limit
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        retire = 1'b1;
        repeat (20) tick();
        retire = 1'b0;
        rd(1, 2'd3, 15);
        rd(1, 2'd0, 15);
        rd(1, 2'd1, 0);
        chk("sat_running_b", 32'(running_b), 1);
        chk("sat_done_b", 32'(done_b), 0);

        tick();
        chk("queue_a_drained", 32'(exp_a.size()), 0);
        chk("queue_b_drained", 32'(exp_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
